test_value_uart_tx: RTL and testbench

- Downstream observer of the MIPS core's 16-bit `test_value` output.
- Detects changes in `test_value` and serialises each new value as a 3-byte UART frame (8N1, LSB first): sync byte 0xA5, then the high byte, then the low byte.
- Gives the bench or board a one-wire trace of program results without probing internal state.

---
 rtl/test_value_uart_tx.sv | 137 +++++++++++++
 tb/tb_test_value_uart_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/test_value_uart_tx.sv
// rtl/test_value_uart_tx.sv - serialises each change of test_value as an 8N1 UART frame
// Frame is SYNC_BYTE, value[15:8], value[7:0]; each byte LSB first with one start and one stop bit.
module test_value_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] test_value,
  input  logic        send_en,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [15:0]   last_sent;
  logic [15:0]   shadow;
  logic [15:0]   prev_value;
  logic          chg_flag;
  logic [7:0]    cur_byte;
  logic [2:0]    next_bit;
  logic          baud_end;

  assign next_bit = bit_idx + 3'd1;
  assign baud_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    cur_byte = shadow[7:0];
    case (byte_idx)
      2'd0:    cur_byte = SYNC_BYTE;
      2'd1:    cur_byte = shadow[15:8];
      default: cur_byte = shadow[7:0];
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      byte_idx   <= 2'd0;
      last_sent  <= 16'h0000;
      shadow     <= 16'h0000;
      prev_value <= 16'h0000;
      chg_flag   <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      prev_value <= test_value;

      // A second input change inside one frame means a value was lost.
      if (busy && (test_value != prev_value)) begin
        if (chg_flag) overrun  <= 1'b1;
        else          chg_flag <= 1'b1;
      end

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (send_en && (test_value != last_sent)) begin
            shadow    <= test_value;
            last_sent <= test_value;
            tx        <= 1'b0;
            busy      <= 1'b1;
            byte_idx  <= 2'd0;
            bit_idx   <= 3'd0;
            chg_flag  <= 1'b0;
            state     <= START;
          end
        end

        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            tx       <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= next_bit;
              tx      <= cur_byte[next_bit];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (byte_idx == 2'd2) begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              tx       <= 1'b0;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_value_uart_tx.sv
// tb/tb_test_value_uart_tx.sv - frame-level reference model and directed/random stimulus for test_value_uart_tx
module tb_test_value_uart_tx;

  localparam int C  = 4;
  localparam int FL = 30 * C;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] test_value = 16'h0000;
  logic        send_en = 1'b0;
  logic        tx, busy, frame_done, overrun;

  always #5 CLK = ~CLK;

  test_value_uart_tx #(.CLKS_PER_BIT(C), .SYNC_BYTE(8'hA5)) dut (
    .CLK(CLK), .Reset(Reset), .test_value(test_value), .send_en(send_en),
    .tx(tx), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a frame is a 30-bit line pattern, each bit lasting C cycles.
  bit          m_active;
  int          m_elapsed;
  bit          m_bits[30];
  logic [15:0] m_last, m_prev;
  bit          m_chg, m_ovr, m_done;

  logic        rec[FL];
  logic [7:0]  decoded[$];
  int          busy_len[$];
  int          done_cnt = 0;
  int          busy_run = 0;

  task automatic model_reset();
    m_active = 0; m_elapsed = 0; m_last = 16'h0; m_prev = 16'h0;
    m_chg = 0; m_ovr = 0; m_done = 0; busy_run = 0;
  endtask

  task automatic model_edge();
    logic [7:0] b;
    if (!Reset) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (m_active) begin
      if (test_value != m_prev) begin
        if (m_chg) m_ovr = 1;
        else       m_chg = 1;
      end
      m_elapsed++;
      if (m_elapsed == FL) begin
        m_active = 0;
        m_done   = 1;
      end
    end else if (send_en && (test_value != m_last)) begin
      m_active = 1; m_elapsed = 0; m_last = test_value; m_chg = 0;
      for (int k = 0; k < 3; k++) begin
        b = (k == 0) ? 8'hA5 : ((k == 1) ? test_value[15:8] : test_value[7:0]);
        m_bits[k*10] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[k*10+1+i] = b[i];
        m_bits[k*10+9] = 1'b1;
      end
    end
    m_prev = test_value;
  endtask

  task automatic cyc();
    logic [7:0] b;
    model_edge();
    @(posedge CLK);
    #1;
    check_val("tx", tx, m_active ? m_bits[m_elapsed / C] : 1'b1);
    check_val("busy", busy, m_active);
    check_val("frame_done", frame_done, m_done);
    check_val("overrun", overrun, m_ovr);
    if (m_active) rec[m_elapsed] = tx;
    if (busy) busy_run++;
    if (frame_done) begin
      done_cnt++;
      busy_len.push_back(busy_run);
      busy_run = 0;
    end
    if (m_done) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 8; i++) b[i] = rec[k*10*C + (1+i)*C + C/2];
        decoded.push_back(b);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic clear_log();
    decoded.delete();
    busy_len.delete();
    done_cnt = 0;
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [7:0] hi, input logic [7:0] lo);
    if (decoded.size() >= idx*3 + 3) begin
      check_val({tag, "_sync"}, decoded[idx*3],   8'hA5);
      check_val({tag, "_hi"},   decoded[idx*3+1], hi);
      check_val({tag, "_lo"},   decoded[idx*3+2], lo);
    end else begin
      check_val({tag, "_present"}, decoded.size(), idx*3 + 3);
    end
  endtask

  logic [15:0] pool[4];

  initial begin
    model_reset();
    Reset = 1'b0; send_en = 1'b1; test_value = 16'h0000;
    run(3);
    Reset = 1'b1;
    run(200);
    check_val("idle_frame_done", done_cnt, 0);

    clear_log();
    test_value = 16'h1234; run(10);
    test_value = 16'h0007; run(20);
    test_value = 16'h0009; run(2*FL + 20);
    check_val("two_frames", done_cnt, 2);
    check_frame("f1234", 0, 8'h12, 8'h34);
    check_frame("f0009", 1, 8'h00, 8'h09);
    if (busy_len.size() > 0) check_val("busy_len", busy_len[0], FL);
    else                     check_val("busy_len_present", busy_len.size(), 1);
    check_val("overrun_set", overrun, 1);

    clear_log();
    send_en = 1'b0; test_value = 16'hBEEF; run(200);
    check_val("gated_no_frame", done_cnt, 0);
    send_en = 1'b1; run(FL + 10);
    check_val("beef_frames", done_cnt, 1);
    check_frame("fbeef", 0, 8'hBE, 8'hEF);

    clear_log();
    test_value = 16'h5A5A; run(50);
    Reset = 1'b0; #1;
    check_val("rst_tx", tx, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_overrun", overrun, 0);
    run(3);
    Reset = 1'b1;
    run(FL + 10);
    check_val("post_rst_frames", done_cnt, 1);
    check_frame("f5a5a", 0, 8'h5A, 8'h5A);

    clear_log();
    test_value = 16'h00FF; run(20);
    test_value = 16'h0100; run(20);
    test_value = 16'h00FF; run(FL + 40);
    check_val("away_back_frames", done_cnt, 1);
    check_frame("f00ff", 0, 8'h00, 8'hFF);
    check_val("away_back_overrun", overrun, 1);

    pool[0] = 16'h0000; pool[1] = 16'hFFFF; pool[2] = 16'h8001; pool[3] = 16'h00FF;
    repeat (2000) begin
      if ($urandom_range(0, 29) == 0)
        test_value = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : 16'($urandom);
      if ($urandom_range(0, 59) == 0) send_en = ~send_en;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
